operand_fetch_stage: RTL

- Issue stage directly upstream of the ALU.
- Holds the 32-entry integer register file and accepts decoded instructions from decode with a valid/ready handshake.
- Resolves operands through a writeback bypass and a busy-bit scoreboard, and registers A, B and the 3-bit ALU control for the ALU.
- Output register drives the ALU A/B/control_signal inputs. Writeback returns results through a dedicated write port.

---
 rtl/operand_fetch_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// -----------------------------------------------------------------------------
// operand_fetch_stage
//
// Issue stage that sits directly in front of the ALU. It owns the integer
// register file, resolves source operands (with a writeback bypass), tracks
// outstanding destinations with a busy-bit scoreboard, and registers the
// A / B / control operands handed to the ALU.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready      decode -> stage handshake
//   in_rs1, in_rs2, in_rd    source and destination register indices
//   in_op                    3-bit ALU control code, passed through unchanged
//   in_imm, in_use_imm       immediate and B-source select
//   wb_en, wb_addr, wb_data  writeback port into the register file
//   flush                    kill the instruction held in the output register
//   out_valid / out_ready    stage -> ALU handshake
//   alu_a, alu_b, alu_ctrl   registered ALU operands and control
//   out_rd                   destination tag travelling with the operands
// -----------------------------------------------------------------------------
module operand_fetch_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    output logic [ADDR_W-1:0] out_rd
);

    localparam int NREGS = 1 << ADDR_W;

    // State
    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_ctrl_q, alu_ctrl_d;
    logic [ADDR_W-1:0] out_rd_q, out_rd_d;

    // Combinational helpers
    logic [NREGS-1:0]  wb_mask;
    logic [NREGS-1:0]  eff_busy;
    logic [DATA_W-1:0] opnd_a, opnd_rs2, opnd_b;
    logic              hazard;
    logic              accept;

    // -------------------------------------------------------------------------
    // Operand resolution, hazard detection and handshake
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        wb_mask = '0;
        if (wb_en) begin
            wb_mask[wb_addr] = 1'b1;
        end

        // A register being written back this cycle is no longer a hazard: its
        // value arrives through the bypass below.
        eff_busy = busy_q & ~wb_mask;

        if (in_rs1 == '0) begin
            opnd_a = '0;
        end else if (wb_en && (wb_addr == in_rs1)) begin
            opnd_a = wb_data;
        end else begin
            opnd_a = rf_q[in_rs1];
        end

        if (in_rs2 == '0) begin
            opnd_rs2 = '0;
        end else if (wb_en && (wb_addr == in_rs2)) begin
            opnd_rs2 = wb_data;
        end else begin
            opnd_rs2 = rf_q[in_rs2];
        end

        opnd_b = in_use_imm ? in_imm : opnd_rs2;

        // busy[0] is held at zero, so rd == 0 never raises the WAW term.
        hazard = eff_busy[in_rs1]
               | (~in_use_imm & eff_busy[in_rs2])
               | eff_busy[in_rd];

        in_ready = ~hazard & (~out_valid_q | out_ready | flush);
        accept   = in_valid & in_ready;
    end

    // -------------------------------------------------------------------------
    // Next-state: register file, scoreboard and output register
    // -------------------------------------------------------------------------
    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_addr != '0)) begin
            rf_d[wb_addr] = wb_data;
        end

        // Later assignments win, which gives the required priority:
        // writeback clear, then flush clear, then accept set.
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (flush && out_valid_q) begin
            busy_d[out_rd_q] = 1'b0;
        end
        if (accept && (in_rd != '0)) begin
            busy_d[in_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        out_valid_d = out_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        out_rd_d    = out_rd_q;
        if (accept) begin
            // A simultaneous flush simply lets the new instruction overwrite
            // the killed one.
            out_valid_d = 1'b1;
            alu_a_d     = opnd_a;
            alu_b_d     = opnd_b;
            alu_ctrl_d  = in_op;
            out_rd_d    = in_rd;
        end else if (out_ready || flush) begin
            out_valid_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the register file is cleared by reset because software relies on
    // every register reading zero after reset; a plain RAM would not be reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q        <= '{default: '0};
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            out_rd_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that all
            // flops update together from the values present before the edge.
            rf_q        <= rf_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign out_rd    = out_rd_q;

endmodule
